pe_col_drain: RTL

Downstream drain collector at the bottom of each int8 output-stationary PE column. During a drain, the column's PEs shift their 48-bit partial sums downward one per cycle. This block captures the ROWS values arriving at the column bottom, saturates each to signed OUT_WIDTH, and buffers them in a FIFO. It presents them on a valid/ready stream to the output writer, and admits a drain only when the FIFO can absorb a full column, because the array cannot be stalled.

---
 rtl/pe_col_drain.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pe_col_drain.sv
// Drain collector at the bottom of an output-stationary PE column: captures one
// word per row, saturates it to OUT_WIDTH and streams it out through a FIFO.
module pe_col_drain #(
   parameter int ROWS       = 16,
   parameter int IN_WIDTH   = 48,
   parameter int OUT_WIDTH  = 32,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    drain_start_in,
   input  logic [IN_WIDTH-1:0]     bottom_in,
   output logic                    drain_rdy_out,
   output logic [OUT_WIDTH-1:0]    m_data_out,
   output logic [$clog2(ROWS)-1:0] m_row_out,
   output logic                    m_last_out,
   output logic                    m_valid_out,
   input  logic                    m_ready_in,
   output logic                    sat_flag_out,
   output logic                    drop_err_out,
   input  logic                    err_clr_in
);

   localparam int RW = $clog2(ROWS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = OUT_WIDTH + RW + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ALIGN   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;

   localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   function automatic logic clamps(input logic signed [IN_WIDTH-1:0] v);
      return (v > SAT_MAX) || (v < SAT_MIN);
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [IN_WIDTH-1:0] v);
      if (v > SAT_MAX)
         return {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (v < SAT_MIN)
         return {1'b1, {(OUT_WIDTH-1){1'b0}}};
      return v[OUT_WIDTH-1:0];
   endfunction

   logic [1:0]                  state;
   logic [RW-1:0]               cnt;
   logic [AW-1:0]               wr_ptr, rd_ptr, rd_next;
   logic [AW:0]                 occ, occ_after_pop, occ_next;
   logic                        push, pop, accept, reject, bypass;
   logic signed [IN_WIDTH-1:0]  bottom_p0;
   logic signed [OUT_WIDTH-1:0] sat_word_p0;
   logic                        clamp_p0;
   logic [EW-1:0]               entry_p0, head;
   logic [EW-1:0]               mem [FIFO_DEPTH];

   // Stage p0: column bottom word saturated and tagged with its row
   assign bottom_p0   = bottom_in;
   assign sat_word_p0 = saturate(bottom_p0);
   assign clamp_p0    = clamps(bottom_p0);
   assign entry_p0    = {(cnt == '0), cnt, sat_word_p0};

   // The array cannot stall, so a drain is admitted only with room for a whole column
   assign drain_rdy_out = !rst && (state == IDLE) && (occ <= (AW+1)'(FIFO_DEPTH - ROWS));
   assign accept        = drain_start_in && drain_rdy_out;
   assign reject        = drain_start_in && !drain_rdy_out;

   assign push          = (state == CAPTURE);
   assign pop           = m_valid_out && m_ready_in;
   assign occ_after_pop = occ - (AW+1)'(pop);
   assign occ_next      = occ_after_pop + (AW+1)'(push);
   assign rd_next       = rd_ptr + AW'(pop);

   // An entry written into an otherwise empty FIFO goes straight to the output register
   assign bypass = push && (occ_after_pop == '0);
   assign head   = bypass ? entry_p0 : mem[rd_next];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= entry_p0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         occ          <= '0;
         m_valid_out  <= 1'b0;
         m_data_out   <= '0;
         m_row_out    <= '0;
         m_last_out   <= 1'b0;
         sat_flag_out <= 1'b0;
         drop_err_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept)
                  state <= ALIGN;
            end
            ALIGN: begin
               state <= CAPTURE;
               cnt   <= RW'(ROWS - 1);
            end
            CAPTURE: begin
               cnt <= cnt - RW'(1);
               if (cnt == '0)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Stage p1: FIFO pointers and the registered stream head
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr      <= rd_next;
         occ         <= occ_next;
         m_valid_out <= (occ_next != '0);
         if (occ_next != '0)
            {m_last_out, m_row_out, m_data_out} <= head;

         if (push && clamp_p0)
            sat_flag_out <= 1'b1;
         else if (err_clr_in)
            sat_flag_out <= 1'b0;

         if (reject)
            drop_err_out <= 1'b1;
         else if (err_clr_in)
            drop_err_out <= 1'b0;
      end
   end

endmodule
